// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use bubbles, branch flush,
// and registered EX-stage forwarding selects derived from an internal MEM/WB shadow.
module hazard_ctrl #(
    parameter int unsigned LU_BUBBLES = 1,
    parameter int unsigned CNT_W      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic       EX_RegWr,
    input  logic       EX_MemRd,
    input  logic [4:0] EX_WrReg,
    input  logic       EX_BrTaken,
    output logic       stall,
    output logic       PC_hold,
    output logic       IFID_hold,
    output logic       IFID_flush,
    output logic [1:0] FwdA,
    output logic [1:0] FwdB
);

    localparam int unsigned REG_W = 5;
    localparam bit MULTI_BUBBLE = (LU_BUBBLES > 1);
    localparam logic [CNT_W-1:0] CNT_INIT = MULTI_BUBBLE ? CNT_W'(LU_BUBBLES - 2) : '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_ALU = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        LUSTALL = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             m_reg_wr;
    logic             m_mem_rd;
    logic [REG_W-1:0] m_wr_reg;
    logic             w_reg_wr;
    logic [REG_W-1:0] w_wr_reg;

    logic hit_ex_rs, hit_ex_rt, hit_m_rs, hit_m_rt, lu;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    // Operand matches against the EX instruction and the MEM shadow; $0 never matches.
    always_comb begin
        hit_ex_rs = EX_RegWr && (EX_WrReg == ID_Rs) && (ID_Rs != '0) && ID_UseRs;
        hit_ex_rt = EX_RegWr && (EX_WrReg == ID_Rt) && (ID_Rt != '0) && ID_UseRt;
        hit_m_rs  = m_reg_wr && (m_wr_reg == ID_Rs) && (ID_Rs != '0) && ID_UseRs;
        hit_m_rt  = m_reg_wr && (m_wr_reg == ID_Rt) && (ID_Rt != '0) && ID_UseRt;
        lu        = EX_MemRd && (hit_ex_rs || hit_ex_rt);
    end

    // A load in EX cannot feed its ALU result; the stall lets it arrive via MEM/WB instead.
    always_comb begin
        fwd_a_nxt = FWD_RF;
        fwd_b_nxt = FWD_RF;
        if (hit_ex_rs && !EX_MemRd) fwd_a_nxt = FWD_ALU;
        else if (hit_m_rs)          fwd_a_nxt = FWD_WB;
        if (hit_ex_rt && !EX_MemRd) fwd_b_nxt = FWD_ALU;
        else if (hit_m_rt)          fwd_b_nxt = FWD_WB;
    end

    // Pipeline control decode; a taken branch always wins over a load-use hold.
    always_comb begin
        stall      = 1'b0;
        PC_hold    = 1'b0;
        IFID_hold  = 1'b0;
        IFID_flush = 1'b0;
        if (!reset) begin
            if (EX_BrTaken) begin
                stall      = 1'b1;
                IFID_flush = 1'b1;
            end else if (state == LUSTALL || lu) begin
                stall     = 1'b1;
                PC_hold   = 1'b1;
                IFID_hold = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            cnt      <= '0;
            m_reg_wr <= 1'b0;
            m_mem_rd <= 1'b0;
            m_wr_reg <= '0;
            w_reg_wr <= 1'b0;
            w_wr_reg <= '0;
            FwdA     <= FWD_RF;
            FwdB     <= FWD_RF;
        end else begin
            m_reg_wr <= EX_RegWr;
            m_mem_rd <= EX_MemRd;
            m_wr_reg <= EX_WrReg;
            w_reg_wr <= m_reg_wr;
            w_wr_reg <= m_wr_reg;

            // A bubble enters EX whenever stall is high, so it must read the register file.
            FwdA <= stall ? FWD_RF : fwd_a_nxt;
            FwdB <= stall ? FWD_RF : fwd_b_nxt;

            case (state)
                RUN: begin
                    if (!EX_BrTaken && lu && MULTI_BUBBLE) begin
                        state <= LUSTALL;
                        cnt   <= CNT_INIT;
                    end
                end
                LUSTALL: begin
                    if (EX_BrTaken || cnt == '0) state <= RUN;
                    else                         cnt   <= cnt - CNT_W'(1);
                end
                default: state <= RUN;
            endcase
        end
    end

    // Load and WB shadow fields are carried for completeness; current selects do not consume them.
    logic unused_shadow;
    assign unused_shadow = ^{m_mem_rd, w_reg_wr, w_wr_reg};

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard controller for the 5-stage MIPS pipeline.
- Sits beside the ID/EX register. It takes the ID-stage source operands, the EX-stage control bits at the ID/EX outputs, and a taken-branch flag resolved in EX.
- It produces the bubble-insert `stall` that drives the ID/EX register, hold/flush controls for PC and IF/ID, and registered forwarding selects for the EX-stage operand muxes.
- It keeps a shadow copy of the MEM and WB destination fields internally, so it needs no EX/MEM or MEM/WB taps.

Parameters:
- LU_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (1..7).
- CNT_W, 3, width of the bubble counter; must satisfy 2^CNT_W > LU_BUBBLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UseRs  in  1  the ID instruction reads rs.
- ID_UseRt  in  1  the ID instruction reads rt.
- EX_RegWr  in  1  the EX instruction writes the register file.
- EX_MemRd  in  1  the EX instruction is a load.
- EX_WrReg  in  5  destination register of the EX instruction.
- EX_BrTaken  in  1  branch/jump resolved taken in EX this cycle.
- stall  out  1  bubble request to ID/EX (zeroes MemWr/MemRd/RegWr there); combinational.
- PC_hold  out  1  PC keeps its value; combinational.
- IFID_hold  out  1  IF/ID keeps its value; combinational.
- IFID_flush  out  1  IF/ID loads a NOP; combinational.
- FwdA  out  2  EX rs operand select, registered: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write data.
- FwdB  out  2  same encoding for the EX rt operand, registered.

Behaviour:
- Reset (async):
  - state=RUN, bubble counter=0.
  - Shadow registers M_RegWr, M_MemRd, M_WrReg, W_RegWr, W_WrReg cleared.
  - FwdA=FwdB=00.
  - All combinational outputs 0 while reset is high.
- Shadow pipeline:
  - Every clk edge: M_* <= EX_*, then W_* <= M_*.
  - It advances unconditionally, because bubbles arrive through ID/EX as zeroed EX_RegWr/EX_MemRd.
- Hazard match:
  - `hitX(r)` is defined as `X_RegWr & (X_WrReg==r) & (r!=0)`.
  - It only counts for an operand whose Use bit is set.
- Load-use detect: `LU = EX_MemRd & (hitEX(ID_Rs)&ID_UseRs | hitEX(ID_Rt)&ID_UseRt)`.
- FSM states:
  - RUN:
    - If EX_BrTaken: IFID_flush=1, stall=1, no hold, stay in RUN.
    - Else if LU: stall=PC_hold=IFID_hold=1. If LU_BUBBLES>1, go to LUSTALL with counter=LU_BUBBLES-2; otherwise stay in RUN.
    - Else all control outputs 0.
  - LUSTALL:
    - stall=PC_hold=IFID_hold=1 and the counter decrements.
    - When the counter is 0, go to RUN next edge.
    - EX_BrTaken in LUSTALL (cannot occur architecturally) still forces IFID_flush=1, hold=0, and a return to RUN.
- Total load-use bubbles is exactly LU_BUBBLES; the held ID instruction re-evaluates in RUN afterwards.
- Branch priority:
  - EX_BrTaken overrides LU in the same cycle.
  - Flush with stall=1 squashes the ID instruction into a bubble and IF/ID loads a NOP.
  - Branch penalty is 2 cycles; PC is redirected externally.
- Forwarding, registered at the edge on which the ID instruction moves to EX:
  - FwdA next = 01 if hitEX(ID_Rs)&ID_UseRs & !EX_MemRd; else 10 if hitM(ID_Rs)&ID_UseRs; else 00.
  - FwdB uses the same rule with ID_Rt/ID_UseRt.
  - EX_MemRd excludes ALU-result forwarding of a load. Because the load-use stall is taken instead, the load reaches MEM/WB and yields 10.
  - EX (nearer) has priority over M.
  - On any edge where stall=1 (load-use or flush), FwdA/FwdB are loaded with 00 since a bubble enters EX.
- Register 0 never produces stall or forwarding.
- Reset mid-stall aborts immediately to RUN with all outputs 0; no residual bubbles.

Test Plan:
1. Reset with counters and shadows dirty → all outputs 0, state RUN. The first cycle after release with ID_Rs=3 and a non-writing EX gives FwdA=00.
2. EX lw $5 (MemRd=1, RegWr=1, WrReg=5) while ID add reads Rs=5, LU_BUBBLES=1 → stall=PC_hold=IFID_hold=1 for exactly 1 cycle. The next cycle has no stall, and the edge into EX gives FwdA=10.
3. EX add $7 (RegWr=1) and ID sub with Rt=7 → no stall, FwdB=01 after the edge. If, in addition, M_WrReg=7 with RegWr set, FwdB is still 01 (EX priority).
4. LU_BUBBLES=3 with a load-use on Rt → stall high for exactly 3 consecutive cycles (RUN→LUSTALL for 2 cycles→RUN), FwdB=00 during those cycles.
5. EX_BrTaken=1 in the same cycle as an LU match → IFID_flush=1, stall=1, PC_hold=IFID_hold=0, and no LUSTALL entry.
6. EX writes $0 with ID_Rs=0 and MemRd=1 → no stall, FwdA=00. Asserting reset in the 2nd cycle of a 3-bubble stall drops stall within the same cycle.
